msk_frame_ctrl: RTL and testbench

MSK_FRAME_CTRL -- requirements
Module: msk_frame_ctrl

---
 rtl/msk_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_msk_frame_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/msk_frame_ctrl.sv
// msk_frame_ctrl: MSK bit-stream framer (sync hunt, length byte, payload bytes). Ports: clk/reset, enable_i, bit_i+bit_valid_i in; byte_o/byte_valid_o/byte_last_o, frame_start_o, frame_err_o, inverted_o, state_o, frame_cnt_o out.
module msk_frame_ctrl #(
  parameter logic [31:0] SYNC_WORD = 32'h1ACF_FC1D,
  parameter int unsigned MAX_ERR = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        bit_i,
  input  logic        bit_valid_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        byte_last_o,
  output logic        frame_start_o,
  output logic        frame_err_o,
  output logic        inverted_o,
  output logic [1:0]  state_o,
  output logic [15:0] frame_cnt_o
);
  typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [31:0] hist_q, hist_d, hist_n, tcnt_q, tcnt_d;
  logic [5:0]  bcnt_q, bcnt_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  sh_q, sh_d, len_q, len_d, bytec_q, bytec_d, byte_q, byte_d, shv;
  logic        bv_q, bv_d, last_q, last_d, start_q, start_d, err_q, err_d, inv_q, inv_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        to_hunt, match, match_inv;
  int unsigned d, dinv;
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    bitn_d  = bitn_q;
    sh_d    = sh_q;
    len_d   = len_q;
    bytec_d = bytec_q;
    byte_d  = byte_q;
    inv_d   = inv_q;
    fcnt_d  = fcnt_q;
    bv_d    = 1'b0;
    last_d  = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;
    to_hunt = 1'b0;
    hist_n  = (hist_q << 1) | {31'd0, bit_i};
    d       = $countones(hist_n ^ SYNC_WORD);
    dinv    = $countones(hist_n ^ ~SYNC_WORD);
    match     = d <= MAX_ERR;
    match_inv = dinv <= MAX_ERR;
    shv     = {sh_q[6:0], bit_i ^ inv_q};
    if (!enable_i) begin
      to_hunt = 1'b1;
      err_d   = state_q != HUNT;
    end else if (state_q == HUNT) begin
      if (bit_valid_i) begin
        hist_d = hist_n;
        bcnt_d = bcnt_q == 6'd32 ? bcnt_q : bcnt_q + 6'd1;
        // bcnt_q >= 31 means this bit completes the first full 32-bit window
        if (bcnt_q >= 6'd31 && (match || match_inv)) begin
          start_d = 1'b1;
          inv_d   = !match;
          state_d = LEN;
          hist_d  = '0;
          bcnt_d  = '0;
          bitn_d  = '0;
          tcnt_d  = '0;
        end
      end
    end else if (bit_valid_i) begin
      tcnt_d = '0;
      sh_d   = shv;
      bitn_d = bitn_q + 3'd1;
      if (bitn_q == 3'd7) begin
        if (state_q == LEN) begin
          len_d   = shv;
          bytec_d = '0;
          state_d = PAYLOAD;
          err_d   = shv == 8'd0;
          to_hunt = shv == 8'd0;
        end else begin
          byte_d  = shv;
          bv_d    = 1'b1;
          bytec_d = bytec_q + 8'd1;
          last_d  = bytec_q + 8'd1 == len_q;
          fcnt_d  = last_d ? fcnt_q + 16'd1 : fcnt_q;
          to_hunt = last_d;
        end
      end
    end else if (tcnt_q == TIMEOUT - 1) begin
      err_d   = 1'b1;
      to_hunt = 1'b1;
    end else begin
      tcnt_d = tcnt_q + 32'd1;
    end
    if (to_hunt) begin
      state_d = HUNT;
      hist_d  = '0;
      bcnt_d  = '0;
      bitn_d  = '0;
      tcnt_d  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      hist_q  <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      bitn_q  <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      bytec_q <= '0;
      byte_q  <= '0;
      bv_q    <= 1'b0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      bitn_q  <= bitn_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      bytec_q <= bytec_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      last_q  <= last_d;
      start_q <= start_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
      fcnt_q  <= fcnt_d;
    end
  end
  assign byte_o        = byte_q;
  assign byte_valid_o  = bv_q;
  assign byte_last_o   = last_q;
  assign frame_start_o = start_q;
  assign frame_err_o   = err_q;
  assign inverted_o    = inv_q;
  assign state_o       = state_q;
  assign frame_cnt_o   = fcnt_q;
endmodule

// File: tb/tb_msk_frame_ctrl.sv
// tb_msk_frame_ctrl: randomized self-checking bench for msk_frame_ctrl against a frame-level reference model.
module tb_msk_frame_ctrl;
  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;
  localparam int TMO = 1024;
  logic clk = 1'b0, reset, enable_i, bit_i, bit_valid_i;
  logic [7:0] byte_o;
  logic byte_valid_o, byte_last_o, frame_start_o, frame_err_o, inverted_o;
  logic [1:0] state_o;
  logic [15:0] frame_cnt_o;
  int checks = 0, errors = 0, n_start = 0, n_err = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [8:0] got_q[$];
  msk_frame_ctrl dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_last_o(byte_last_o),
    .frame_start_o(frame_start_o), .frame_err_o(frame_err_o), .inverted_o(inverted_o),
    .state_o(state_o), .frame_cnt_o(frame_cnt_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (byte_valid_o) got_q.push_back({byte_last_o, byte_o});
    if (frame_start_o) n_start++;
    if (frame_err_o) n_err++;
    if (byte_valid_o || byte_last_o || frame_start_o || frame_err_o) begin
      checks++;
      if (int'(byte_valid_o) + int'(frame_start_o) + int'(frame_err_o) > 1 || (byte_last_o && !byte_valid_o)) begin
        errors++;
        $display("FAIL pulse_excl: got bv=%b last=%b start=%b err=%b, required at most one pulse", byte_valid_o, byte_last_o, frame_start_o, frame_err_o);
      end
    end
  end
  task automatic send_bit(input logic b, input int gap);
    bit_i = b;
    bit_valid_i = 1'b1;
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 31; i >= 0; i--) send_bit(w[i], i == 0 ? 0 : $urandom_range(0, maxgap));
  endtask
  task automatic send_byte(input logic [7:0] v, input logic inv, input int maxgap);
    for (int i = 7; i >= 0; i--) send_bit(v[i] ^ inv, i == 0 ? 0 : $urandom_range(0, maxgap));
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    checks++;
    if ({byte_o, byte_valid_o, byte_last_o, frame_start_o, frame_err_o, inverted_o, state_o, frame_cnt_o} !== 31'd0) begin
      errors++;
      $display("FAIL reset: got byte=%h bv=%b last=%b st=%b err=%b inv=%b state=%0d fc=%0d, required all 0", byte_o, byte_valid_o, byte_last_o, frame_start_o, frame_err_o, inverted_o, state_o, frame_cnt_o);
    end
  endtask
  task automatic test_clean_frame;
    got_q.delete();
    send_word(SYNC, 0);
    checks++;
    if (frame_start_o !== 1'b1 || state_o !== 2'd1) begin errors++; $display("FAIL clean_start: got start=%b state=%0d, required 1/1", frame_start_o, state_o); end
    send_byte(8'h02, 1'b0, 0);
    checks++;
    if (state_o !== 2'd2) begin errors++; $display("FAIL clean_len: got state=%0d, required 2", state_o); end
    send_byte(8'hA5, 1'b0, 0);
    checks++;
    if ({byte_valid_o, byte_last_o, byte_o} !== {2'b10, 8'hA5}) begin errors++; $display("FAIL clean_b0: got bv=%b last=%b byte=%h, required 1/0/a5", byte_valid_o, byte_last_o, byte_o); end
    send_byte(8'h3C, 1'b0, 0);
    exp_fc++;
    checks++;
    if ({byte_valid_o, byte_last_o, byte_o} !== {2'b11, 8'h3C} || frame_cnt_o !== exp_fc || state_o !== 2'd0) begin
      errors++;
      $display("FAIL clean_b1: got bv=%b last=%b byte=%h fc=%0d state=%0d, required 1/1/3c/%0d/0", byte_valid_o, byte_last_o, byte_o, frame_cnt_o, state_o, exp_fc);
    end
  endtask
  task automatic drop_enable;
    enable_i = 1'b0;
    idle(1);
    enable_i = 1'b1;
  endtask
  task automatic test_errored_sync;
    int s0, e0;
    send_word(SYNC ^ 32'h0002_0008, 0);
    checks++;
    if (frame_start_o !== 1'b1 || inverted_o !== 1'b0) begin errors++; $display("FAIL sync_2err: got start=%b inv=%b, required 1/0", frame_start_o, inverted_o); end
    e0 = n_err;
    drop_enable();
    checks++;
    if (frame_err_o !== 1'b1 || state_o !== 2'd0) begin errors++; $display("FAIL enable_abort: got err=%b state=%0d, required 1/0", frame_err_o, state_o); end
    idle(3);
    checks++;
    if (n_err != e0 + 1) begin errors++; $display("FAIL enable_abort_once: got %0d pulses, required 1", n_err - e0); end
    s0 = n_start;
    send_word(SYNC ^ 32'h8001_0100, 0);
    idle(2);
    checks++;
    if (n_start != s0 || state_o !== 2'd0) begin errors++; $display("FAIL sync_3err: got starts=%0d state=%0d, required 0/0", n_start - s0, state_o); end
    e0 = n_err;
    drop_enable();
    idle(2);
    checks++;
    if (n_err != e0) begin errors++; $display("FAIL enable_hunt: got %0d err pulses, required 0", n_err - e0); end
  endtask
  task automatic test_inverted;
    got_q.delete();
    send_word(~SYNC, 0);
    checks++;
    if (inverted_o !== 1'b1 || frame_start_o !== 1'b1) begin errors++; $display("FAIL inv_sync: got inv=%b start=%b, required 1/1", inverted_o, frame_start_o); end
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    exp_fc++;
    idle(1);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 9'h011 || got_q[1] !== 9'h122 || frame_cnt_o !== exp_fc) begin
      errors++;
      $display("FAIL inv_bytes: got n=%0d fc=%0d, required 2 bytes 11,22(last) fc=%0d", got_q.size(), frame_cnt_o, exp_fc);
    end
  endtask
  task automatic test_timeout;
    int e0, n;
    logic [7:0] v;
    v = 8'($urandom);
    got_q.delete();
    send_word(SYNC, 1);
    send_byte(8'h04, 1'b0, 1);
    send_byte(v, 1'b0, 1);
    e0 = n_err;
    n = 0;
    while (!frame_err_o && n < 3 * TMO) begin idle(1); n++; end
    checks++;
    if (n != TMO) begin errors++; $display("FAIL timeout_len: got %0d idle clocks, required %0d", n, TMO); end
    idle(3);
    checks++;
    if (n_err != e0 + 1 || state_o !== 2'd0 || frame_cnt_o !== exp_fc) begin
      errors++;
      $display("FAIL timeout_after: got pulses=%0d state=%0d fc=%0d, required 1/0/%0d", n_err - e0, state_o, frame_cnt_o, exp_fc);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, v}) begin errors++; $display("FAIL timeout_byte: got n=%0d, required one byte %h", got_q.size(), v); end
  endtask
  task automatic test_zero_length;
    logic [7:0] v;
    v = 8'($urandom);
    send_word(SYNC, 0);
    send_byte(8'h00, 1'b0, 0);
    checks++;
    if (frame_err_o !== 1'b1 || state_o !== 2'd0) begin errors++; $display("FAIL zero_len: got err=%b state=%0d, required 1/0", frame_err_o, state_o); end
    got_q.delete();
    send_word(SYNC, 0);
    send_byte(8'h01, 1'b0, 0);
    send_byte(v, 1'b0, 0);
    exp_fc++;
    checks++;
    if (byte_valid_o !== 1'b1 || byte_last_o !== 1'b1 || byte_o !== v || frame_cnt_o !== exp_fc) begin
      errors++;
      $display("FAIL zero_next: got bv=%b last=%b byte=%h fc=%0d, required 1/1/%h/%0d", byte_valid_o, byte_last_o, byte_o, frame_cnt_o, v, exp_fc);
    end
  endtask
  task automatic test_reset_mid;
    int e0;
    send_word(SYNC, 0);
    send_byte(8'h03, 1'b0, 0);
    send_byte(8'h5A, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
    e0 = n_err;
    reset = 1'b1;
    idle(1);
    test_reset();
    reset = 1'b0;
    exp_fc = 16'd0;
    idle(3);
    checks++;
    if (n_err != e0 || state_o !== 2'd0) begin errors++; $display("FAIL reset_mid: got err pulses=%0d state=%0d, required 0/0", n_err - e0, state_o); end
  endtask
  task automatic test_random;
    logic [7:0] pl[$];
    logic [31:0] w;
    logic inv;
    int len, s0, g;
    for (int f = 0; f < 20; f++) begin
      inv = 1'($urandom);
      len = $urandom_range(1, 4);
      g = $urandom_range(0, 2);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      w = inv ? ~SYNC : SYNC;
      for (int k = $urandom_range(0, 2); k > 0; k--) w[$urandom_range(0, 31)] ^= 1'b1;
      got_q.delete();
      s0 = n_start;
      send_word(w, g);
      send_byte(8'(len), inv, g);
      foreach (pl[i]) send_byte(pl[i], inv, g);
      exp_fc++;
      idle($urandom_range(1, 4));
      checks++;
      if (n_start != s0 + 1 || inverted_o !== inv || frame_cnt_o !== exp_fc || got_q.size() != len) begin
        errors++;
        $display("FAIL rand_frame%0d: got starts=%0d inv=%b fc=%0d n=%0d, required 1/%b/%0d/%0d", f, n_start - s0, inverted_o, frame_cnt_o, got_q.size(), inv, exp_fc, len);
      end else begin
        foreach (pl[i]) begin
          checks++;
          if (got_q[i] !== {i == len - 1, pl[i]}) begin errors++; $display("FAIL rand_byte%0d_%0d: got %h, required %h", f, i, got_q[i], {i == len - 1, pl[i]}); end
        end
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    enable_i = 1'b1;
    bit_i = 1'b0;
    bit_valid_i = 1'b0;
    idle(3);
    test_reset();
    reset = 1'b0;
    idle(2);
    test_clean_frame();
    idle(2);
    test_errored_sync();
    test_inverted();
    idle(2);
    test_timeout();
    test_zero_length();
    idle(2);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
